// File: rtl/vdma_frame_buf_ctrl.sv
// Per-channel triple-buffer base-address scheduler: rotates write/read frame slots for NCH channels.
// Latency: one axi_aclk edge from pulse (or base change) to updated indices and registered addresses.
// Backpressure: none; event pulses are consumed on the cycle they are sampled, and a disabled channel drops them.
//
// Ports:
//   axi_aclk, axi_reset         clock, synchronous active-high reset
//   ch_enable[NCH]              per-channel enable; a 0->1 edge reinitialises the slot state
//   ch_baseaddr[NCH]            slot-0 base address per channel
//   wr_frame_done[NCH]          writer finished the frame in its current slot (1-cycle pulse)
//   rd_frame_start[NCH]         reader is starting a frame (1-cycle pulse)
//   wr_addr/rd_addr[NCH]        registered slot base addresses for writer and reader
//   frame_valid[NCH]            at least one complete frame since reset/enable
//   drop_cnt/repeat_cnt[NCH]    saturating counts of unread-overwritten frames and stale read starts
module vdma_frame_buf_ctrl #(
  parameter int ASIZE      = 29,
  parameter int NCH        = 8,
  parameter int FRAME_STEP = 2211840,
  parameter int CNT_W      = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_reset,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [ASIZE-1:0] ch_baseaddr [NCH],
  input  logic [NCH-1:0]   wr_frame_done,
  input  logic [NCH-1:0]   rd_frame_start,
  output logic [ASIZE-1:0] wr_addr [NCH],
  output logic [ASIZE-1:0] rd_addr [NCH],
  output logic [NCH-1:0]   frame_valid,
  output logic [CNT_W-1:0] drop_cnt [NCH],
  output logic [CNT_W-1:0] repeat_cnt [NCH]
);

  localparam logic [ASIZE-1:0] STEP1 = ASIZE'(FRAME_STEP);
  localparam logic [ASIZE-1:0] STEP2 = ASIZE'(2 * FRAME_STEP);

  // Slot index -> byte offset from the channel base (addresses wrap at 2^ASIZE).
  function automatic logic [ASIZE-1:0] slot_off(input logic [1:0] idx);
    case (idx)
      2'd1:    return STEP1;
      2'd2:    return STEP2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       wr_idx   [NCH];
  logic [1:0]       rd_idx   [NCH];
  logic [1:0]       last_idx [NCH];
  logic [NCH-1:0]   fresh;
  logic [NCH-1:0]   en_q;

  logic [1:0]       wr_idx_n   [NCH];
  logic [1:0]       rd_idx_n   [NCH];
  logic [1:0]       last_idx_n [NCH];
  logic [NCH-1:0]   fresh_n;
  logic [NCH-1:0]   frame_valid_n;
  logic [CNT_W-1:0] drop_cnt_n   [NCH];
  logic [CNT_W-1:0] repeat_cnt_n [NCH];

  // Slot rotation. wr_idx never equals rd_idx or last_idx, so the writer
  // only ever lands on the slot nobody is reading and that holds no pending frame.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_idx_n[c]      = wr_idx[c];
      rd_idx_n[c]      = rd_idx[c];
      last_idx_n[c]    = last_idx[c];
      fresh_n[c]       = fresh[c];
      frame_valid_n[c] = frame_valid[c];
      drop_cnt_n[c]    = drop_cnt[c];
      repeat_cnt_n[c]  = repeat_cnt[c];

      if (ch_enable[c] && !en_q[c]) begin
        // Re-enable restarts the rotation but keeps the statistics.
        wr_idx_n[c]      = 2'd1;
        rd_idx_n[c]      = 2'd0;
        last_idx_n[c]    = 2'd0;
        fresh_n[c]       = 1'b0;
        frame_valid_n[c] = 1'b0;
      end else if (ch_enable[c]) begin
        case ({wr_frame_done[c], rd_frame_start[c]})
          2'b10: begin
            last_idx_n[c]    = wr_idx[c];
            wr_idx_n[c]      = 2'd3 - wr_idx[c] - rd_idx[c];
            if (fresh[c]) drop_cnt_n[c] = sat_inc(drop_cnt[c]);
            fresh_n[c]       = 1'b1;
            frame_valid_n[c] = 1'b1;
          end
          2'b01: begin
            if (fresh[c]) begin
              rd_idx_n[c] = last_idx[c];
              fresh_n[c]  = 1'b0;
            end else begin
              repeat_cnt_n[c] = sat_inc(repeat_cnt[c]);
            end
          end
          2'b11: begin
            // Reader takes the frame just finished; writer reuses the slot the reader left.
            rd_idx_n[c]      = wr_idx[c];
            last_idx_n[c]    = wr_idx[c];
            wr_idx_n[c]      = rd_idx[c];
            fresh_n[c]       = 1'b0;
            frame_valid_n[c] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      for (int c = 0; c < NCH; c++) begin
        wr_idx[c]     <= 2'd1;
        rd_idx[c]     <= 2'd0;
        last_idx[c]   <= 2'd0;
        drop_cnt[c]   <= '0;
        repeat_cnt[c] <= '0;
        wr_addr[c]    <= ch_baseaddr[c] + STEP1;
        rd_addr[c]    <= ch_baseaddr[c];
      end
      fresh       <= '0;
      frame_valid <= '0;
      // Seeded from the live enable so a channel already enabled at reset sees no spurious edge.
      en_q        <= ch_enable;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_idx[c]     <= wr_idx_n[c];
        rd_idx[c]     <= rd_idx_n[c];
        last_idx[c]   <= last_idx_n[c];
        drop_cnt[c]   <= drop_cnt_n[c];
        repeat_cnt[c] <= repeat_cnt_n[c];
        wr_addr[c]    <= ch_baseaddr[c] + slot_off(wr_idx_n[c]);
        rd_addr[c]    <= ch_baseaddr[c] + slot_off(rd_idx_n[c]);
      end
      fresh       <= fresh_n;
      frame_valid <= frame_valid_n;
      en_q        <= ch_enable;
    end
  end

endmodule

// File: tb/tb_vdma_frame_buf_ctrl.sv
// Bench for vdma_frame_buf_ctrl: directed channel-0 scenarios with literal
// expectations, random activity on channel 3, and a per-cycle model compare.
module tb_vdma_frame_buf_ctrl;
  localparam int ASIZE      = 29;
  localparam int NCH        = 8;
  localparam int FRAME_STEP = 2211840;
  localparam int CNT_W      = 16;

  logic             axi_aclk = 1'b0;
  logic             axi_reset;
  logic [NCH-1:0]   ch_enable;
  logic [ASIZE-1:0] ch_baseaddr [NCH];
  logic [NCH-1:0]   wr_frame_done;
  logic [NCH-1:0]   rd_frame_start;
  logic [ASIZE-1:0] wr_addr [NCH];
  logic [ASIZE-1:0] rd_addr [NCH];
  logic [NCH-1:0]   frame_valid;
  logic [CNT_W-1:0] drop_cnt [NCH];
  logic [CNT_W-1:0] repeat_cnt [NCH];

  vdma_frame_buf_ctrl #(
    .ASIZE(ASIZE), .NCH(NCH), .FRAME_STEP(FRAME_STEP), .CNT_W(CNT_W)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset), .ch_enable(ch_enable),
    .ch_baseaddr(ch_baseaddr), .wr_frame_done(wr_frame_done),
    .rd_frame_start(rd_frame_start), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .frame_valid(frame_valid), .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: which slot the writer fills, which the reader shows, which holds
  // the newest finished frame, and whether that frame has not been read yet.
  int               m_wr [NCH];
  int               m_rd [NCH];
  int               m_last [NCH];
  bit               m_fresh [NCH];
  bit               m_fv [NCH];
  int               m_drop [NCH];
  int               m_rep [NCH];
  bit               m_en_prev [NCH];
  logic [ASIZE-1:0] exp_wr [NCH];
  logic [ASIZE-1:0] exp_rd [NCH];

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ASIZE-1:0] slot_addr(input logic [ASIZE-1:0] base, input int slot);
    logic [63:0] t;
    t = 64'(base) + 64'(slot) * 64'(FRAME_STEP);
    return t[ASIZE-1:0];
  endfunction

  task automatic model_init(input int c);
    m_wr[c] = 1; m_rd[c] = 0; m_last[c] = 0; m_fresh[c] = 0; m_fv[c] = 0;
  endtask

  // Evaluated at the active edge with the inputs the DUT samples there.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit wd, rs;
      int old_wr;
      wd = wr_frame_done[c];
      rs = rd_frame_start[c];
      if (axi_reset) begin
        model_init(c);
        m_drop[c] = 0;
        m_rep[c]  = 0;
      end else if (ch_enable[c] && !m_en_prev[c]) begin
        model_init(c);
      end else if (ch_enable[c]) begin
        if (wd && rs) begin
          old_wr    = m_wr[c];
          m_wr[c]   = m_rd[c];
          m_rd[c]   = old_wr;
          m_last[c] = old_wr;
          m_fresh[c] = 0;
          m_fv[c]    = 1;
        end else if (wd) begin
          if (m_fresh[c] && m_drop[c] < CNT_MAX) m_drop[c]++;
          m_last[c]  = m_wr[c];
          m_wr[c]    = 3 - m_wr[c] - m_rd[c];
          m_fresh[c] = 1;
          m_fv[c]    = 1;
        end else if (rs) begin
          if (m_fresh[c]) begin
            m_rd[c]    = m_last[c];
            m_fresh[c] = 0;
          end else if (m_rep[c] < CNT_MAX) begin
            m_rep[c]++;
          end
        end
      end
      m_en_prev[c] = ch_enable[c];
      exp_wr[c] = slot_addr(ch_baseaddr[c], m_wr[c]);
      exp_rd[c] = slot_addr(ch_baseaddr[c], m_rd[c]);
    end
    if (axi_reset) chk_on = 1'b1;
  endtask

  always @(negedge axi_aclk) begin
    if (chk_on) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("wr_addr[%0d]", c), 64'(wr_addr[c]), 64'(exp_wr[c]));
        chk($sformatf("rd_addr[%0d]", c), 64'(rd_addr[c]), 64'(exp_rd[c]));
        chk($sformatf("frame_valid[%0d]", c), 64'(frame_valid[c]), 64'(m_fv[c]));
        chk($sformatf("drop_cnt[%0d]", c), 64'(drop_cnt[c]), 64'(m_drop[c]));
        chk($sformatf("repeat_cnt[%0d]", c), 64'(repeat_cnt[c]), 64'(m_rep[c]));
      end
    end
  end

  // One clock: model follows the edge, then channel 3 gets fresh random
  // activity and channel-0 pulses are cleared for the caller to set again.
  task automatic cyc();
    @(posedge axi_aclk);
    model_step();
    #1;
    wr_frame_done     = '0;
    rd_frame_start    = '0;
    wr_frame_done[3]  = 1'($urandom_range(0, 1));
    rd_frame_start[3] = 1'($urandom_range(0, 1));
    ch_enable[3]      = ($urandom_range(0, 9) != 0);
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk({"lit_", name}, act, exp);
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    cyc();
    axi_reset = 1'b0;
  endtask

  initial begin
    axi_reset      = 1'b1;
    ch_enable      = '1;
    wr_frame_done  = '0;
    rd_frame_start = '0;
    for (int c = 0; c < NCH; c++) ch_baseaddr[c] = ASIZE'(c * 32'h0100_0000);
    ch_baseaddr[0] = '0;
    ch_baseaddr[3] = 29'h1FFF_0000;
    for (int c = 0; c < NCH; c++) m_en_prev[c] = 1'b1;
    cyc();
    cyc();
    axi_reset = 1'b0;

    // Reset state; channel 3 slot 1 wraps past 2^29.
    @(negedge axi_aclk);
    lit("rst_wr0", 64'(wr_addr[0]), 64'h21C000);
    lit("rst_rd0", 64'(rd_addr[0]), 64'h0);
    lit("rst_fv0", 64'(frame_valid[0]), 64'h0);
    lit("rst_drop0", 64'(drop_cnt[0]), 64'h0);
    lit("rst_wrap3", 64'(wr_addr[3]), 64'h20C000);

    // One frame written, then read.
    wr_frame_done[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("wd_wr0", 64'(wr_addr[0]), 64'h438000);
    lit("wd_rd0", 64'(rd_addr[0]), 64'h0);
    lit("wd_fv0", 64'(frame_valid[0]), 64'h1);
    rd_frame_start[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("rs_rd0", 64'(rd_addr[0]), 64'h21C000);
    lit("rs_wr0", 64'(wr_addr[0]), 64'h438000);

    // Two writes without a read: one drop, writer 1->2->1.
    do_reset();
    wr_frame_done[0] = 1'b1; cyc();
    wr_frame_done[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("drop_cnt0", 64'(drop_cnt[0]), 64'h1);
    lit("drop_wr0", 64'(wr_addr[0]), 64'h21C000);
    rd_frame_start[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("drop_rd0", 64'(rd_addr[0]), 64'h438000);

    // Three stale read starts.
    for (int i = 0; i < 3; i++) begin
      rd_frame_start[0] = 1'b1; cyc();
    end
    @(negedge axi_aclk);
    lit("rep_cnt0", 64'(repeat_cnt[0]), 64'h3);
    lit("rep_rd0", 64'(rd_addr[0]), 64'h438000);

    // Reset while a pulse is present: reset wins.
    axi_reset = 1'b1; wr_frame_done[0] = 1'b1; cyc();
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    lit("rstpulse_wr0", 64'(wr_addr[0]), 64'h21C000);
    lit("rstpulse_rep0", 64'(repeat_cnt[0]), 64'h0);

    // Simultaneous pulses from wr=1, rd=0.
    wr_frame_done[0] = 1'b1; rd_frame_start[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("sim_rd0", 64'(rd_addr[0]), 64'h21C000);
    lit("sim_wr0", 64'(wr_addr[0]), 64'h0);
    lit("sim_drop0", 64'(drop_cnt[0]), 64'h0);
    lit("sim_rep0", 64'(repeat_cnt[0]), 64'h0);
    rd_frame_start[0] = 1'b1; cyc();   // stale read -> repeat_cnt=1

    // Disabled: pulses ignored, addresses follow the new base.
    ch_enable[0] = 1'b0; wr_frame_done[0] = 1'b1; rd_frame_start[0] = 1'b1; cyc();
    ch_baseaddr[0] = 29'h100000; wr_frame_done[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("dis_wr0", 64'(wr_addr[0]), 64'h100000);
    lit("dis_rd0", 64'(rd_addr[0]), 64'h31C000);
    lit("dis_fv0", 64'(frame_valid[0]), 64'h1);

    // Re-enable: state reinitialised, pulse in that cycle ignored, counters kept.
    ch_enable[0] = 1'b1; wr_frame_done[0] = 1'b1; cyc();
    @(negedge axi_aclk);
    lit("en_wr0", 64'(wr_addr[0]), 64'h31C000);
    lit("en_rd0", 64'(rd_addr[0]), 64'h100000);
    lit("en_fv0", 64'(frame_valid[0]), 64'h0);
    lit("en_rep0", 64'(repeat_cnt[0]), 64'h1);

    // Background activity on channel 3 with channel 0 idle.
    for (int i = 0; i < 60; i++) cyc();
    @(negedge axi_aclk);
    lit("idle_wr0", 64'(wr_addr[0]), 64'h31C000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
